// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use and branch stall/flush,
// multi-cycle mul/div sequencing, and a saturating fetch-stall performance counter.
module hazard_unit #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic [1:0]       resultSrc_E,
  input  logic             PCSrc_E,
  input  logic             md_start_E,
  input  logic [4:0]       rd_M,
  input  logic             regWrite_M,
  input  logic [4:0]       rd_W,
  input  logic             regWrite_W,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        state;
  logic [3:0]       count;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0] fwd_a, fwd_b;
  logic       lw, md_stall, done_i, stall_f_i;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic       wm,
    input logic [4:0] rdw,
    input logic       ww
  );
    if (wm && rdm != 5'd0 && rdm == rs)      fwd_sel = 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) fwd_sel = 2'b01;
    else                                     fwd_sel = 2'b00;
  endfunction

  always_comb begin
    fwd_a     = fwd_sel(rs1_E, rd_M, regWrite_M, rd_W, regWrite_W);
    fwd_b     = fwd_sel(rs2_E, rd_M, regWrite_M, rd_W, regWrite_W);
    lw        = (resultSrc_E == 2'b01) && (rd_E != 5'd0) &&
                ((rd_E == rs1_D) || (rd_E == rs2_D));
    md_stall  = 1'b0;
    done_i    = 1'b0;
    case (state)
      IDLE: md_stall = md_start_E;
      BUSY: begin
        md_stall = (count != 4'd0);
        done_i   = (count == 4'd0);
      end
      default: ;
    endcase
    stall_f_i = lw | md_stall;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (md_start_E) begin
          state <= BUSY;
          count <= 4'(MD_LATENCY - 2);
        end
        BUSY: if (count != 4'd0) count <= count - 4'd1;
              else               state <= IDLE;
        default: state <= IDLE;
      endcase
      if (stall_f_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  // A taken branch must still clear IF/ID while a load-use stall holds it, so
  // only the mul/div stall (which freezes the whole front end) blocks flush_D.
  assign forwardA_E = reset ? fwd_a : '0;
  assign forwardB_E = reset ? fwd_b : '0;
  assign stall_F    = reset & stall_f_i;
  assign stall_D    = reset & stall_f_i;
  assign stall_E    = reset & md_stall;
  assign flush_M    = reset & md_stall;
  assign flush_E    = reset & (lw | PCSrc_E) & ~md_stall;
  assign flush_D    = reset & PCSrc_E & ~md_stall;
  assign md_busy    = reset & (state == BUSY);
  assign md_done    = reset & done_i;
  assign stall_cnt  = reset ? cnt_q : '0;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table for the combinational
// paths plus hand-written mul/div, reset-abort and counter-saturation sequences.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [1:0] resultSrc_E;
  logic       PCSrc_E, md_start_E, regWrite_M, regWrite_W;
  logic [1:0] forwardA_E, forwardB_E;
  logic       stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, md_busy, md_done;
  logic [3:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_cnt = 4'd0;

  always #5 clk = ~clk;

  hazard_unit #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .resultSrc_E(resultSrc_E), .PCSrc_E(PCSrc_E), .md_start_E(md_start_E),
    .rd_M(rd_M), .regWrite_M(regWrite_M), .rd_W(rd_W), .regWrite_W(regWrite_W),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E;
    logic [1:0] rsrc;
    logic       pcsrc;
    logic [4:0] rd_M;
    logic       wm;
    logic [4:0] rd_W;
    logic       ww;
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0; rd_M = '0; rd_W = '0;
    resultSrc_E = '0; PCSrc_E = 1'b0; md_start_E = 1'b0; regWrite_M = 1'b0; regWrite_W = 1'b0;
  endtask

  task automatic md_chk(input string nm, input logic s, input logic b, input logic d);
    chk({nm, "_stall_E"}, 32'(stall_E), 32'(s));
    chk({nm, "_flush_M"}, 32'(flush_M), 32'(s));
    chk({nm, "_stall_F"}, 32'(stall_F), 32'(s));
    chk({nm, "_md_busy"}, 32'(md_busy), 32'(b));
    chk({nm, "_md_done"}, 32'(md_done), 32'(d));
    chk({nm, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
    if (s && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
  endtask

  function automatic logic [15:0] all_outs();
    return {forwardA_E, forwardB_E, stall_F, stall_D, stall_E, flush_D, flush_E,
            flush_M, md_busy, md_done, stall_cnt};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 2'b00, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd0, 5'd0, 5'd4, 5'd9, 5'd0, 2'b00, 1'b0, 5'd4, 1'b1, 5'd9, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{5'd12, 5'd0, 5'd0, 5'd0, 5'd12, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 2'b00, 1'b0, 5'd6, 1'b0, 5'd6, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held low with active inputs: every output must read zero.
    clear_inputs();
    reset = 1'b0;
    rs1_E = 5'd5; rd_M = 5'd5; regWrite_M = 1'b1; PCSrc_E = 1'b1; md_start_E = 1'b1;
    resultSrc_E = 2'b01; rd_E = 5'd7; rs2_D = 5'd7;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("reset_outputs", 32'(all_outs()), 32'd0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    #2;
    chk("post_reset_outputs", 32'(all_outs()), 32'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rs1_D = vecs[i].rs1_D; rs2_D = vecs[i].rs2_D; rs1_E = vecs[i].rs1_E;
      rs2_E = vecs[i].rs2_E; rd_E = vecs[i].rd_E; resultSrc_E = vecs[i].rsrc;
      PCSrc_E = vecs[i].pcsrc; rd_M = vecs[i].rd_M; regWrite_M = vecs[i].wm;
      rd_W = vecs[i].rd_W; regWrite_W = vecs[i].ww;
      #2;
      chk($sformatf("v%0d_forwardA", i), 32'(forwardA_E), 32'(vecs[i].fa));
      chk($sformatf("v%0d_forwardB", i), 32'(forwardB_E), 32'(vecs[i].fb));
      chk($sformatf("v%0d_stall_F", i), 32'(stall_F), 32'(vecs[i].sf));
      chk($sformatf("v%0d_stall_D", i), 32'(stall_D), 32'(vecs[i].sd));
      chk($sformatf("v%0d_flush_D", i), 32'(flush_D), 32'(vecs[i].fd));
      chk($sformatf("v%0d_flush_E", i), 32'(flush_E), 32'(vecs[i].fe));
      chk($sformatf("v%0d_stall_E", i), 32'(stall_E), 32'd0);
      chk($sformatf("v%0d_flush_M", i), 32'(flush_M), 32'd0);
      chk($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(exp_cnt));
      if (vecs[i].sf && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    end

    // Mul/div with md_start_E held: three stall cycles, done in the fourth.
    @(negedge clk); clear_inputs(); md_start_E = 1'b1; #2; md_chk("md_c1", 1'b1, 1'b0, 1'b0);
    @(negedge clk); #2; md_chk("md_c2", 1'b1, 1'b1, 1'b0);
    @(negedge clk); #2; md_chk("md_c3", 1'b1, 1'b1, 1'b0);
    @(negedge clk); #2; md_chk("md_c4", 1'b0, 1'b1, 1'b1);
    @(negedge clk); md_start_E = 1'b0; #2; md_chk("md_idle", 1'b0, 1'b0, 1'b0);
    @(negedge clk); #2; md_chk("md_idle2", 1'b0, 1'b0, 1'b0);

    // Restart, then abort with reset in the second BUSY cycle.
    @(negedge clk); md_start_E = 1'b1; #2; md_chk("md2_c1", 1'b1, 1'b0, 1'b0);
    @(negedge clk); #2; md_chk("md2_c2", 1'b1, 1'b1, 1'b0);
    @(negedge clk); reset = 1'b0; #2;
    chk("md_abort_outputs", 32'(all_outs()), 32'd0);
    @(negedge clk); reset = 1'b1; md_start_E = 1'b0; exp_cnt = 4'd0; #2;
    md_chk("md_after_abort", 1'b0, 1'b0, 1'b0);

    // Continuous load-use stall: counter must saturate at 4'hF.
    @(negedge clk); resultSrc_E = 2'b01; rd_E = 5'd7; rs2_D = 5'd7;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    chk("stall_cnt_mid", 32'(stall_cnt), 32'd10);
    repeat (9) @(posedge clk);
    @(negedge clk); #2;
    chk("stall_cnt_sat", 32'(stall_cnt), 32'hF);
    chk("sat_stall_F", 32'(stall_F), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
